// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display sequencer.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int          NUM_DIGITS = 8;
    localparam int          BCD_DIGITS = 5;
    localparam int          BCD_W      = BCD_DIGITS * 4;
    localparam logic [7:0]  AN_RESET   = 8'b1000_0000;

    // Add-3 correction applied to every BCD nibble that is 5 or more,
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Dwell prescaler: one-cycle tick every TICK_DIV clocks, on the wrap cycle.
// Latency: first tick TICK_DIV-1 clocks after reset release (counter starts at 0).
// Backpressure: none, free-running.
module seg_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..TICK_DIV-1 and wrap; tick marks the last count.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_display_sequencer.sv
// Converts a 16-bit switch value to 5 BCD digits (shift-add-3) and scans 8 digit positions.
// Latency: done 17 clocks after the load edge; scan outputs show the new value one clock later.
// Backpressure: load while busy is held in a one-deep pending slot, newest value wins.
module seg_display_sequencer
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [7:0]  an_sel,
    output logic [3:0]  opcode,
    output logic        blank_dec
);

    logic tick;

    seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_t           state_q,    state_d;
    logic [15:0]      bin_sr_q,   bin_sr_d;
    logic [BCD_W-1:0] bcd_q,      bcd_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic             pend_vld_q, pend_vld_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
    logic             done_q,     done_d;
    logic [7:0]       an_sel_q,   an_sel_d;
    logic [3:0]       opcode_q,   opcode_d;
    logic             blank_q,    blank_d;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] hi;

    // Conversion FSM, pending slot and display commit.
    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        disp_bcd_d = disp_bcd_q;
        done_d     = 1'b0;
        adj        = '0;
        case (state_q)
            IDLE: begin
                // A slot filled during the final COMMIT is drained from here.
                if (load) begin
                    bin_sr_d   = sw;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = CONVERT;
                end else if (pend_vld_q) begin
                    bin_sr_d   = pend_val_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                adj               = bcd_adjust(bcd_q);
                {bcd_d, bin_sr_d} = {adj, bin_sr_q} << 1;
                cnt_d             = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = COMMIT;
                end
                if (load) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = sw;
                end
            end
            COMMIT: begin
                disp_bcd_d = bcd_q;
                done_d     = 1'b1;
                if (pend_vld_q) begin
                    bin_sr_d   = pend_val_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = CONVERT;
                end else begin
                    state_d = IDLE;
                end
                // A load this cycle is kept even when the old slot is consumed.
                if (load) begin
                    pend_vld_d = 1'b1;
                    pend_val_d = sw;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan: rotate on tick and derive digit code / blank from the select being loaded.
    always_comb begin
        an_sel_d = tick ? {an_sel_q[0], an_sel_q[7:1]} : an_sel_q;
        opcode_d = 4'd0;
        blank_d  = 1'b0;
        hi       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_sel_d[i]) begin
                hi       = disp_bcd_q >> (4 * i);
                opcode_d = hi[3:0];
                blank_d  = (i != 0) && (hi == '0);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bin_sr_q   <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            disp_bcd_q <= '0;
            done_q     <= 1'b0;
            an_sel_q   <= AN_RESET;
            opcode_q   <= 4'd0;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            disp_bcd_q <= disp_bcd_d;
            done_q     <= done_d;
            an_sel_q   <= an_sel_d;
            opcode_q   <= opcode_d;
            blank_q    <= blank_d;
        end
    end

    assign busy      = (state_q != IDLE) | pend_vld_q;
    assign done      = done_q;
    assign an_sel    = an_sel_q;
    assign opcode    = opcode_q;
    assign blank_dec = blank_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Directed bench for seg_display_sequencer with a 4-clock digit dwell.
// Latency: checks done at 17 clocks after load and full-scan display contents.
// Backpressure: exercises pending-slot overwrite during a conversion.
module tb_seg_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        load;
    logic        busy;
    logic        done;
    logic [7:0]  an_sel;
    logic [3:0]  opcode;
    logic        blank_dec;

    int tests = 0;
    int fails = 0;

    seg_display_sequencer #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .an_sel    (an_sel),
        .opcode    (opcode),
        .blank_dec (blank_dec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse load for one edge; returns just after that edge (E0).
    task automatic do_load(input logic [15:0] v);
        sw   = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Clocks from the load edge until done is seen; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Watch a full scan; entry p of exp is {blank_dec, opcode} at position p.
    task automatic check_display(input string tag, input logic [39:0] exp);
        logic [39:0] got;
        logic [7:0]  seen;
        got  = '0;
        seen = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int p = 0; p < 8; p++) begin
                if (an_sel === (8'h01 << p)) begin
                    got[p*5 +: 5] = {blank_dec, opcode};
                    seen[p]       = 1'b1;
                end
            end
        end
        chk($sformatf("%s_all_positions_seen", tag), {32'd0, seen}, {32'd0, 8'hFF});
        for (int p = 7; p >= 0; p--) begin
            chk($sformatf("%s_pos%0d", tag, p), {35'd0, got[p*5 +: 5]}, {35'd0, exp[p*5 +: 5]});
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int first_done;
        int second_done;
        int busy_gap;

        reset = 1'b1;
        sw    = 16'd0;
        load  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_an_sel", {32'd0, an_sel}, {32'd0, 8'h80});
        chk("rst_opcode", {36'd0, opcode}, 40'd0);
        chk("rst_blank",  {39'd0, blank_dec}, 40'd1);
        chk("rst_busy",   {39'd0, busy}, 40'd0);
        chk("rst_done",   {39'd0, done}, 40'd0);
        tick();
        tick();
        chk("rst_hold_an_sel", {32'd0, an_sel}, {32'd0, 8'h80});

        // Release reset; the select must hold 3 edges and rotate on the 4th.
        reset = 1'b1;
        tick(); tick(); tick();
        chk("rot_before_wrap", {32'd0, an_sel}, {32'd0, 8'h80});
        tick();
        chk("rot_first", {32'd0, an_sel}, {32'd0, 8'h40});
        tick(); tick(); tick(); tick();
        chk("rot_second", {32'd0, an_sel}, {32'd0, 8'h20});

        // Single conversion of 12345.
        do_load(16'd12345);
        chk("single_busy", {39'd0, busy}, 40'd1);
        wait_done(lat);
        chk("single_latency", lat, 40'd17);
        tick();
        chk("single_done_one_cycle", {39'd0, done}, 40'd0);
        chk("single_idle", {39'd0, busy}, 40'd0);
        check_display("d12345", {5'h10, 5'h10, 5'h10, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05});

        // Leading-zero blanking.
        do_load(16'd45);
        wait_done(lat);
        chk("d45_latency", lat, 40'd17);
        check_display("d45", {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h04, 5'h05});

        do_load(16'd0);
        wait_done(lat);
        chk("d0_latency", lat, 40'd17);
        check_display("d0", {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00});

        // Pending overwrite: 5123 at E0, 65535 at E3, 45 at E4.
        do_load(16'd5123);
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        busy_gap    = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 2) begin
                sw   = 16'd65535;
                load = 1'b1;
            end
            if (k == 3) sw = 16'd45;
            if (k == 4) load = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) first_done = k;
                if (n_done == 2) second_done = k;
            end
            if (k < 34 && busy !== 1'b1) busy_gap++;
        end
        chk("pend_done_count", n_done, 40'd2);
        chk("pend_first_done", first_done, 40'd17);
        chk("pend_second_done", second_done, 40'd34);
        chk("pend_busy_gap", busy_gap, 40'd0);
        chk("pend_final_idle", {39'd0, busy}, 40'd0);
        check_display("pend", {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h04, 5'h05});

        // Maximum value.
        do_load(16'd65535);
        wait_done(lat);
        chk("max_latency", lat, 40'd17);
        check_display("d65535", {5'h10, 5'h10, 5'h10, 5'h06, 5'h05, 5'h05, 5'h03, 5'h05});

        // Reset in the middle of a conversion.
        do_load(16'd12345);
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", {39'd0, busy}, 40'd0);
        chk("midrst_an_sel", {32'd0, an_sel}, {32'd0, 8'h80});
        chk("midrst_blank", {39'd0, blank_dec}, 40'd1);
        chk("midrst_opcode", {36'd0, opcode}, 40'd0);
        #3 reset = 1'b1;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("midrst_no_done", n_done, 40'd0);
        check_display("midrst", {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00});

        do_load(16'd7);
        wait_done(lat);
        chk("after_rst_latency", lat, 40'd17);
        check_display("d7", {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h07});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_sequencer.md
# seg_display_sequencer

Sequencer for the 8-digit seven-segment path. It takes a 16-bit switch value and converts it to 5 BCD digits with an iterative shift-add-3 engine under a load/busy/done handshake. It commits the result atomically to a display register. It then drives the scan: a rotating one-hot anode select plus the matching digit code and leading-zero blank. It sits between the switch inputs and the segment decoder, and replaces the free-running rotator + combinational converter pair.

## Interface
Parameters:
- TICK_DIV, 100000: clocks per digit dwell; legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- sw  in  16  unsigned binary value to display.
- load  in  1  conversion request.
  - Sampled on every posedge.
  - Level-high for N cycles counts as N requests.
- busy  out  1  high while a conversion is in progress or pending.
- done  out  1  one-cycle pulse when a new value is committed to the display.
- an_sel  out  8  one-hot, active-high digit select; bit 7 = most significant position.
- opcode  out  4  BCD digit for the selected position.
- blank_dec  out  1  1 = selected digit must be blanked.

## Operation
Conversion FSM has three states: IDLE, CONVERT, COMMIT.
- IDLE
  - If load=1: bin_sr←sw, bcd←0, cnt←0, go to CONVERT.
- CONVERT
  - Each cycle, for every one of the 5 BCD nibbles, add 3 if the nibble is ≥5.
  - Then shift {bcd, bin_sr} left by 1 as a single 36-bit vector. The bin_sr MSB enters the bcd LSB.
  - cnt increments each cycle; after the 16th shift (cnt=15), go to COMMIT.
- COMMIT
  - disp_bcd←bcd (20 bits) and done=1 for this cycle.
  - If pend_valid: load bin_sr←pend_val, clear pend_valid, go to CONVERT.
  - Otherwise go to IDLE.
- Pending buffer (one deep):
  - load=1 in CONVERT or COMMIT sets pend_valid=1 and pend_val=sw.
  - A later load overwrites pend_val; only the newest value is kept.
  - A load in COMMIT is pended even if pend_valid is already being consumed that cycle.
- busy = (state≠IDLE) | pend_valid.
- Arithmetic: the 16-bit maximum 65535 fits in 5 BCD digits, so there is no overflow. Digit positions 5–7 are always 0.

Scan:
- Free-running tick counter counts 0..TICK_DIV-1.
- The cycle it wraps, an_sel rotates right: 1000_0000→0100_0000→…→0000_0001→1000_0000.
- For position p (p = bit index of an_sel):
  - opcode = disp_bcd nibble p for p≤4, else 0.
  - blank_dec = 1 if p≠0 and all of digits p..7 are 0. The units digit is never blanked, so a value of 0 shows "0".
- an_sel, opcode and blank_dec are registered together. They are updated every clock from the an_sel value being loaded that edge, so they are always mutually consistent.

## Timing
- Reset values:
  - Outputs: an_sel=8'b1000_0000, opcode=0, blank_dec=1, busy=0, done=0.
  - Internal: disp_bcd=0, pend_valid=0, tick counter=0, state=IDLE.
- Latency:
  - load sampled at edge E0 → busy=1 after E0.
  - Shifts occur at E1..E16; COMMIT is the cycle after E16.
  - done=1 and disp_bcd updated after E17.
  - opcode/blank_dec reflect the new value after E18, which is 18 clocks after the load edge.
- Back-to-back: a pending conversion starts CONVERT directly from COMMIT with no IDLE cycle. busy stays high throughout.
- Commit and scan tick on the same edge: outputs use the old disp_bcd at that edge and the new one from the next edge.
- Reset asserted mid-conversion: the async clear aborts the conversion, discards the pending value, returns the display to 0, and restarts the scan at position 7.
- sw is only sampled on load edges; sw changes otherwise have no effect.

## Structure
- Package seg_pkg holds:
  - the state enum (IDLE, CONVERT, COMMIT);
  - NUM_DIGITS=8;
  - BCD_DIGITS=5;
  - AN_RESET=8'b1000_0000.
- One sub-module, seg_tick_gen (parameter TICK_DIV; ports clk, reset, tick): the dwell prescaler producing a one-cycle tick at wrap.
- The FSM, pending buffer, converter and scan register live in the top.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold reset=0, then release.
  - During reset: an_sel=1000_0000, opcode=0, blank_dec=1, busy=0.
  - After release, an_sel rotates every 4 clocks.
- Single conversion: sw=12345, load=1 for 1 cycle.
  - done pulses exactly 17 clocks after the load edge.
  - Over a full scan, positions 4..0 show opcode 1,2,3,4,5 with blank_dec=0; positions 7..5 have blank_dec=1.
- Leading zeros: sw=45 and sw=0.
  - sw=45: positions 7..2 blank, position 1 shows 4, position 0 shows 5.
  - sw=0: only position 0 unblanked, showing opcode 0.
- Pending overwrite: load sw=5123, then 3 cycles later load 65535, then load 45.
  - Exactly two done pulses, 17 cycles apart.
  - busy stays high continuously between them.
  - Final display is 00045; 65535 is never committed.
- Maximum value: sw=65535.
  - Digits 6,5,5,3,5 are shown with no blanking on positions 4..0.
- Reset mid-operation: assert reset 8 cycles into a conversion of 12345.
  - done never pulses and the display reads 0.
  - A subsequent load of 7 shows opcode 7 at position 0.
